// File: rtl/poly_mod_result_norm_pkg.sv
// rtl/poly_mod_result_norm_pkg.sv - shared types and width helpers for the result normaliser
package poly_norm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CARRY,
        RED,
        OUT
    } state_t;

    // Room for every word plus a full coefficient of carry headroom, so the
    // resolved value is never truncated before reduction.
    function automatic int acc_bits(input int i_word, input int word_bits, input int coef_bits);
        return i_word * word_bits + coef_bits;
    endfunction

    function automatic int sub_cnt_bits(input int max_sub);
        return $clog2(max_sub + 1);
    endfunction

endpackage

// File: rtl/poly_mod_result_norm_if.sv
// rtl/poly_mod_result_norm_if.sv - input/output handshake bundle; POLY_NORM_ERR_EN adds o_err/o_sub_cnt
interface poly_mod_result_norm_if #(
    parameter int WORD_BITS = 32,
    parameter int NUM_WORDS = 32,
    parameter int I_WORD    = NUM_WORDS + 1,
    parameter int COEF_BITS = WORD_BITS + 1
`ifdef POLY_NORM_ERR_EN
    , parameter int SC_BITS = 4
`endif
);

    logic                                 i_val;
    logic [I_WORD-1:0][COEF_BITS-1:0]     i_dat;
    logic                                 o_rdy;
    logic                                 o_val;
    logic [WORD_BITS*NUM_WORDS-1:0]       o_dat;
    logic                                 i_rdy;
`ifdef POLY_NORM_ERR_EN
    logic                                 o_err;
    logic [SC_BITS-1:0]                   o_sub_cnt;

    modport master (
        output i_val, i_dat, i_rdy,
        input  o_rdy, o_val, o_dat, o_err, o_sub_cnt
    );

    modport slave (
        input  i_val, i_dat, i_rdy,
        output o_rdy, o_val, o_dat, o_err, o_sub_cnt
    );
`else
    modport master (
        output i_val, i_dat, i_rdy,
        input  o_rdy, o_val, o_dat
    );

    modport slave (
        input  i_val, i_dat, i_rdy,
        output o_rdy, o_val, o_dat
    );
`endif

endinterface

// File: rtl/poly_mod_result_norm_mod_cond_sub.sv
// rtl/poly_mod_result_norm_mod_cond_sub.sv - one combinational compare-and-subtract step of the modulus
module mod_cond_sub #(
    parameter int                  ACC_BITS = 1061,
    parameter int                  MOD_BITS = 1024,
    parameter logic [MOD_BITS-1:0] MODULUS  = '1
) (
    input  logic [ACC_BITS-1:0] acc,
    output logic [ACC_BITS-1:0] acc_next,
    output logic                ge
);

    localparam logic [ACC_BITS-1:0] MOD_EXT = ACC_BITS'(MODULUS);

    assign ge       = (acc >= MOD_EXT);
    assign acc_next = ge ? (acc - MOD_EXT) : acc;

endmodule

// File: rtl/poly_mod_result_norm.sv
// rtl/poly_mod_result_norm.sv - serial carry resolve + bounded modular reduction; POLY_NORM_ERR_EN adds o_err/o_sub_cnt
module poly_mod_result_norm
    import poly_norm_pkg::*;
#(
    parameter int                            WORD_BITS       = 32,
    parameter int                            NUM_WORDS       = 32,
    parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS        = ~((WORD_BITS*NUM_WORDS)'(104)),
    parameter int                            REDUN_WORD_BITS = 1,
    parameter int                            I_WORD          = NUM_WORDS + 1,
    parameter int                            COEF_BITS       = WORD_BITS + REDUN_WORD_BITS,
    parameter int                            MAX_SUB         = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    poly_mod_result_norm_if.slave  bus
);

    localparam int ACC_BITS = acc_bits(I_WORD, WORD_BITS, COEF_BITS);
    localparam int SC_BITS  = sub_cnt_bits(MAX_SUB);
    localparam int IDX_BITS = (I_WORD > 1) ? $clog2(I_WORD) : 1;
    localparam int OUT_BITS = WORD_BITS * NUM_WORDS;
    localparam int CAR_BITS = COEF_BITS + 1 - WORD_BITS;

    state_t                           state;
    logic [I_WORD-1:0][COEF_BITS-1:0] coef_buf;
    logic [IDX_BITS-1:0]              idx;
    logic [CAR_BITS-1:0]              carry;
    logic [ACC_BITS-1:0]              acc;
    logic [ACC_BITS-1:0]              acc_sub;
    logic [SC_BITS-1:0]               sub_cnt;
    logic                             ge;
    logic [COEF_BITS:0]               sum;

    assign sum = {1'b0, coef_buf[idx]} + (COEF_BITS+1)'(carry);

    mod_cond_sub #(
        .ACC_BITS (ACC_BITS),
        .MOD_BITS (OUT_BITS),
        .MODULUS  (MODULUS)
    ) u_cond_sub (
        .acc      (acc),
        .acc_next (acc_sub),
        .ge       (ge)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            bus.o_rdy     <= 1'b1;
            bus.o_val     <= 1'b0;
            bus.o_dat     <= '0;
            coef_buf      <= '0;
            idx           <= '0;
            carry         <= '0;
            acc           <= '0;
            sub_cnt       <= '0;
`ifdef POLY_NORM_ERR_EN
            bus.o_err     <= 1'b0;
            bus.o_sub_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_val && bus.o_rdy) begin
                        coef_buf  <= bus.i_dat;
                        idx       <= '0;
                        carry     <= '0;
                        acc       <= '0;
                        sub_cnt   <= '0;
                        bus.o_rdy <= 1'b0;
                        state     <= CARRY;
                    end
                end
                CARRY: begin
                    acc[idx*WORD_BITS +: WORD_BITS] <= sum[WORD_BITS-1:0];
                    carry <= sum[COEF_BITS:WORD_BITS];
                    if (idx == IDX_BITS'(I_WORD - 1)) begin
                        // Final carry lands in the headroom above the top word.
                        acc[ACC_BITS-1 -: COEF_BITS] <= COEF_BITS'(sum[COEF_BITS:WORD_BITS]);
                        state <= RED;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RED: begin
                    if (ge && (sub_cnt < SC_BITS'(MAX_SUB))) begin
                        acc     <= acc_sub;
                        sub_cnt <= sub_cnt + 1'b1;
                    end else begin
                        // Either fully reduced or out of subtraction budget.
                        bus.o_dat     <= acc[OUT_BITS-1:0];
                        bus.o_val     <= 1'b1;
`ifdef POLY_NORM_ERR_EN
                        bus.o_err     <= ge;
                        bus.o_sub_cnt <= sub_cnt;
`endif
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (bus.i_rdy) begin
                        bus.o_val <= 1'b0;
                        bus.o_rdy <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
